// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute stage bundle: D-side control word and operands, stall/flush
// controls, and the registered E-side copy presented to execute.
// Ports: master = decode/hazard side (drives D + StallE/FlushE, observes E);
//        slave  = the pipeline register (samples D, drives E).
// Optional: IDEX_BUBBLE_CNT_EN adds BubbleCntE (32-bit bubble-load counter).
interface id_ex_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  // hazard-unit controls
  logic               StallE;
  logic               FlushE;

  // decode side
  logic               ValidD;
  logic               RegWriteD;
  logic               MemWriteD;
  logic               PCBranchD;
  logic               SrcBSelD;
  logic               MemtoRegD;
  logic [1:0]         SrcASelD;
  logic [3:0]         ALUopD;
  logic [2:0]         immSelD;
  logic [2:0]         strCtrlD;
  logic [XLEN-1:0]    RD1D;
  logic [XLEN-1:0]    RD2D;
  logic [XLEN-1:0]    PCD;
  logic [XLEN-1:0]    PCPlus4D;
  logic [XLEN-1:0]    ImmExtD;
  logic [RADDR_W-1:0] Rs1D;
  logic [RADDR_W-1:0] Rs2D;
  logic [RADDR_W-1:0] RdD;

  // execute side
  logic               ValidE;
  logic               RegWriteE;
  logic               MemWriteE;
  logic               PCBranchE;
  logic               SrcBSelE;
  logic               MemtoRegE;
  logic [1:0]         SrcASelE;
  logic [3:0]         ALUopE;
  logic [2:0]         immSelE;
  logic [2:0]         strCtrlE;
  logic [XLEN-1:0]    RD1E;
  logic [XLEN-1:0]    RD2E;
  logic [XLEN-1:0]    PCE;
  logic [XLEN-1:0]    PCPlus4E;
  logic [XLEN-1:0]    ImmExtE;
  logic [RADDR_W-1:0] Rs1E;
  logic [RADDR_W-1:0] Rs2E;
  logic [RADDR_W-1:0] RdE;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]        BubbleCntE;
`endif

  modport master (
    output StallE, FlushE,
    output ValidD, RegWriteD, MemWriteD, PCBranchD, SrcBSelD, MemtoRegD,
    output SrcASelD, ALUopD, immSelD, strCtrlD,
    output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE,
    input  SrcASelE, ALUopE, immSelE, strCtrlE,
    input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
`ifdef IDEX_BUBBLE_CNT_EN
    , input BubbleCntE
`endif
  );

  modport slave (
    input  StallE, FlushE,
    input  ValidD, RegWriteD, MemWriteD, PCBranchD, SrcBSelD, MemtoRegD,
    input  SrcASelD, ALUopD, immSelD, strCtrlD,
    input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE,
    output SrcASelE, ALUopE, immSelE, strCtrlE,
    output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
`ifdef IDEX_BUBBLE_CNT_EN
    , output BubbleCntE
`endif
  );

endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register of the RV32I core, with per-slot valid bit.
// Latency: 1 cycle (D sampled on rising clk edge appears on E after that edge).
// Backpressure: StallE holds every E output; FlushE (wins over StallE) loads a bubble.
// Ports: clk, rst_n (async active-low), pipe (id_ex_pipe_reg_if.slave).
// Optional: define IDEX_BUBBLE_CNT_EN to add BubbleCntE, a wrapping count of
//           edges on which a bubble was loaded.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  id_ex_pipe_reg_if.slave pipe
);

  // Everything the execute stage sees, held as one word so reset, bubble and
  // capture are each a single assignment.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_write;
    logic               pc_branch;
    logic               src_b_sel;
    logic               mem_to_reg;
    logic [1:0]         src_a_sel;
    logic [3:0]         alu_op;
    logic [2:0]         imm_sel;
    logic [2:0]         str_ctrl;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    imm_ext;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
  } stage_t;

  // Bubble: nothing valid, no side-effecting control set. SrcASel idles at
  // the rs1 encoding so a bubble looks like a harmless register-operand op.
  function automatic stage_t bubble_value();
    stage_t b;
    b           = '0;
    b.src_a_sel = 2'b11;
    return b;
  endfunction

  localparam stage_t BUBBLE = bubble_value();

  stage_t d_word;
  stage_t e_q;
  logic   load_bubble;

  // Capture word assembled from the decode-side inputs.
  always_comb begin
    d_word            = '0;
    d_word.valid      = 1'b1;
    d_word.reg_write  = pipe.RegWriteD;
    d_word.mem_write  = pipe.MemWriteD;
    d_word.pc_branch  = pipe.PCBranchD;
    d_word.src_b_sel  = pipe.SrcBSelD;
    d_word.mem_to_reg = pipe.MemtoRegD;
    d_word.src_a_sel  = pipe.SrcASelD;
    d_word.alu_op     = pipe.ALUopD;
    d_word.imm_sel    = pipe.immSelD;
    d_word.str_ctrl   = pipe.strCtrlD;
    d_word.rd1        = pipe.RD1D;
    d_word.rd2        = pipe.RD2D;
    d_word.pc         = pipe.PCD;
    d_word.pc_plus4   = pipe.PCPlus4D;
    d_word.imm_ext    = pipe.ImmExtD;
    d_word.rs1        = pipe.Rs1D;
    d_word.rs2        = pipe.Rs2D;
    d_word.rd         = pipe.RdD;
  end

  // A bubble enters on flush (regardless of stall) or on an unstalled edge
  // whose decode slot is empty. Invalid decode payload is dropped entirely
  // rather than captured with valid=0, so no control bit can leak.
  assign load_bubble = pipe.FlushE | (~pipe.StallE & ~pipe.ValidD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= BUBBLE;
    end else if (load_bubble) begin
      e_q <= BUBBLE;
    end else if (!pipe.StallE) begin
      e_q <= d_word;
    end
  end

  assign pipe.ValidE    = e_q.valid;
  assign pipe.RegWriteE = e_q.reg_write;
  assign pipe.MemWriteE = e_q.mem_write;
  assign pipe.PCBranchE = e_q.pc_branch;
  assign pipe.SrcBSelE  = e_q.src_b_sel;
  assign pipe.MemtoRegE = e_q.mem_to_reg;
  assign pipe.SrcASelE  = e_q.src_a_sel;
  assign pipe.ALUopE    = e_q.alu_op;
  assign pipe.immSelE   = e_q.imm_sel;
  assign pipe.strCtrlE  = e_q.str_ctrl;
  assign pipe.RD1E      = e_q.rd1;
  assign pipe.RD2E      = e_q.rd2;
  assign pipe.PCE       = e_q.pc;
  assign pipe.PCPlus4E  = e_q.pc_plus4;
  assign pipe.ImmExtE   = e_q.imm_ext;
  assign pipe.Rs1E      = e_q.rs1;
  assign pipe.Rs2E      = e_q.rs2;
  assign pipe.RdE       = e_q.rd;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;

  // Stall-only edges are not bubble loads; flush+stall counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign pipe.BubbleCntE = bubble_cnt;
`endif

  // A bubble must never carry a side-effecting control.
  bubble_quiet_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    !e_q.valid |-> !(e_q.reg_write | e_q.mem_write | e_q.pc_branch | e_q.mem_to_reg)
  );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(32), .RADDR_W(5)) pipe ();

  id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pipe)
  );

  // Reference: the execute slot is either "empty" or "a copy of what decode
  // offered at the last accepting edge".
  typedef struct {
    bit        valid;
    bit        rw, mw, pcb, sbs, m2r;
    bit [1:0]  sa;
    bit [3:0]  alu;
    bit [2:0]  imm, str;
    bit [31:0] rd1, rd2, pc, pc4, immx;
    bit [4:0]  rs1, rs2, rd;
  } rec_t;

  rec_t        exp_e;
  bit   [31:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic rec_t empty_slot();
    rec_t r;
    r       = '{default: '0};
    r.sa    = 2'b11;
    return r;
  endfunction

  function automatic rec_t decode_offer();
    rec_t r;
    r.valid = 1'b1;
    r.rw  = pipe.RegWriteD;  r.mw  = pipe.MemWriteD; r.pcb = pipe.PCBranchD;
    r.sbs = pipe.SrcBSelD;   r.m2r = pipe.MemtoRegD; r.sa  = pipe.SrcASelD;
    r.alu = pipe.ALUopD;     r.imm = pipe.immSelD;   r.str = pipe.strCtrlD;
    r.rd1 = pipe.RD1D;       r.rd2 = pipe.RD2D;      r.pc  = pipe.PCD;
    r.pc4 = pipe.PCPlus4D;   r.immx = pipe.ImmExtD;
    r.rs1 = pipe.Rs1D;       r.rs2 = pipe.Rs2D;      r.rd  = pipe.RdD;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ValidE"},    32'(pipe.ValidE),    32'(exp_e.valid));
    check({tag, ".RegWriteE"}, 32'(pipe.RegWriteE), 32'(exp_e.rw));
    check({tag, ".MemWriteE"}, 32'(pipe.MemWriteE), 32'(exp_e.mw));
    check({tag, ".PCBranchE"}, 32'(pipe.PCBranchE), 32'(exp_e.pcb));
    check({tag, ".SrcBSelE"},  32'(pipe.SrcBSelE),  32'(exp_e.sbs));
    check({tag, ".MemtoRegE"}, 32'(pipe.MemtoRegE), 32'(exp_e.m2r));
    check({tag, ".SrcASelE"},  32'(pipe.SrcASelE),  32'(exp_e.sa));
    check({tag, ".ALUopE"},    32'(pipe.ALUopE),    32'(exp_e.alu));
    check({tag, ".immSelE"},   32'(pipe.immSelE),   32'(exp_e.imm));
    check({tag, ".strCtrlE"},  32'(pipe.strCtrlE),  32'(exp_e.str));
    check({tag, ".RD1E"},      pipe.RD1E,           exp_e.rd1);
    check({tag, ".RD2E"},      pipe.RD2E,           exp_e.rd2);
    check({tag, ".PCE"},       pipe.PCE,            exp_e.pc);
    check({tag, ".PCPlus4E"},  pipe.PCPlus4E,       exp_e.pc4);
    check({tag, ".ImmExtE"},   pipe.ImmExtE,        exp_e.immx);
    check({tag, ".Rs1E"},      32'(pipe.Rs1E),      32'(exp_e.rs1));
    check({tag, ".Rs2E"},      32'(pipe.Rs2E),      32'(exp_e.rs2));
    check({tag, ".RdE"},       32'(pipe.RdE),       32'(exp_e.rd));
`ifdef IDEX_BUBBLE_CNT_EN
    check({tag, ".BubbleCntE"}, pipe.BubbleCntE, exp_cnt);
`endif
  endtask

  // Inputs are already driven (after a negedge). Predict the slot after the
  // coming rising edge, take the edge, then compare at the next falling edge.
  task automatic tick(input string tag);
    rec_t nxt;
    bit   empty_load;
    empty_load = pipe.FlushE || (!pipe.StallE && !pipe.ValidD);
    if (!rst_n)              nxt = empty_slot();
    else if (pipe.FlushE)    nxt = empty_slot();
    else if (pipe.StallE)    nxt = exp_e;
    else if (pipe.ValidD)    nxt = decode_offer();
    else                     nxt = empty_slot();
    @(posedge clk);
    exp_e = nxt;
    if (!rst_n)          exp_cnt = 0;
    else if (empty_load) exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic clear_d();
    pipe.StallE = 0; pipe.FlushE = 0; pipe.ValidD = 0;
    pipe.RegWriteD = 0; pipe.MemWriteD = 0; pipe.PCBranchD = 0;
    pipe.SrcBSelD = 0; pipe.MemtoRegD = 0; pipe.SrcASelD = 2'b11;
    pipe.ALUopD = 0; pipe.immSelD = 0; pipe.strCtrlD = 0;
    pipe.RD1D = 0; pipe.RD2D = 0; pipe.PCD = 0; pipe.PCPlus4D = 0; pipe.ImmExtD = 0;
    pipe.Rs1D = 0; pipe.Rs2D = 0; pipe.RdD = 0;
  endtask

  task automatic rand_d();
    pipe.ValidD    = ($urandom_range(0, 9) < 7);
    pipe.StallE    = ($urandom_range(0, 3) == 0);
    pipe.FlushE    = ($urandom_range(0, 6) == 0);
    pipe.RegWriteD = 1'($urandom);  pipe.MemWriteD = 1'($urandom);
    pipe.PCBranchD = 1'($urandom);  pipe.SrcBSelD  = 1'($urandom);
    pipe.MemtoRegD = 1'($urandom);  pipe.SrcASelD  = 2'($urandom);
    pipe.ALUopD    = 4'($urandom);  pipe.immSelD   = 3'($urandom);
    pipe.strCtrlD  = 3'($urandom);
    pipe.RD1D = $urandom; pipe.RD2D = $urandom; pipe.PCD = $urandom;
    pipe.PCPlus4D = $urandom; pipe.ImmExtD = $urandom;
    pipe.Rs1D = 5'($urandom); pipe.Rs2D = 5'($urandom); pipe.RdD = 5'($urandom);
  endtask

  initial begin
    exp_e   = empty_slot();
    exp_cnt = 0;
    clear_d();

    // reset state
    @(negedge clk);
    check_all("reset");
    check("reset.SrcASelE", 32'(pipe.SrcASelE), 32'd3);
    rst_n = 1'b1;

    // normal load
    pipe.ValidD = 1; pipe.RegWriteD = 1; pipe.ALUopD = 4'b1000;
    pipe.RD1D = 32'h0000_0005; pipe.RdD = 5'd7;
    tick("load");
    check("load.ValidE", 32'(pipe.ValidE), 32'd1);
    check("load.ALUopE", 32'(pipe.ALUopE), 32'h8);
    check("load.RdE",    32'(pipe.RdE),    32'd7);

    // asynchronous reset mid-cycle with the slot loaded
    #2 rst_n = 1'b0;
    #1;
    exp_e = empty_slot(); exp_cnt = 0;
    check_all("async_rst");
    check("async_rst.ValidE", 32'(pipe.ValidE), 32'd0);
    tick("in_rst");
    rst_n = 1'b1;

    // stall holds an ADD while decode offers a store
    clear_d();
    pipe.ValidD = 1; pipe.RegWriteD = 1; pipe.RdD = 5'd3; pipe.RD1D = 32'h11; pipe.RD2D = 32'h22;
    tick("add");
    pipe.StallE = 1; pipe.RegWriteD = 0; pipe.MemWriteD = 1; pipe.RdD = 5'd9;
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.RdE",       32'(pipe.RdE),       32'd3);
    check("stall.MemWriteE", 32'(pipe.MemWriteE), 32'd0);
    pipe.StallE = 0;
    tick("unstall");
    check("unstall.RdE",       32'(pipe.RdE),       32'd9);
    check("unstall.MemWriteE", 32'(pipe.MemWriteE), 32'd1);

    // flush wins over stall
    pipe.StallE = 1; pipe.FlushE = 1;
    tick("flush_stall");
    check("flush_stall.MemWriteE", 32'(pipe.MemWriteE), 32'd0);
    check("flush_stall.ValidE",    32'(pipe.ValidE),    32'd0);

    // invalid decode slot drops its payload
    clear_d();
    pipe.RegWriteD = 1; pipe.MemWriteD = 1; pipe.RD1D = 32'hDEAD_BEEF;
    tick("invalid");
    check("invalid.RD1E",      pipe.RD1E,           32'd0);
    check("invalid.RegWriteE", 32'(pipe.RegWriteE), 32'd0);

`ifdef IDEX_BUBBLE_CNT_EN
    rst_n = 1'b0; clear_d(); tick("cnt_rst"); rst_n = 1'b1;
    pipe.FlushE = 1;                    tick("cnt_flush");
    pipe.FlushE = 0; pipe.StallE = 1;   tick("cnt_stall");
    pipe.StallE = 0; pipe.ValidD = 0;   tick("cnt_empty");
    pipe.StallE = 1; pipe.FlushE = 1;   tick("cnt_fs");
    clear_d(); pipe.ValidD = 1;         tick("cnt_load");
    check("cnt.seq", pipe.BubbleCntE, 32'd3);
    dut.bubble_cnt = 32'hFFFF_FFFF; exp_cnt = 32'hFFFF_FFFF;
    pipe.FlushE = 1;                    tick("cnt_wrap");
    check("cnt.wrap", pipe.BubbleCntE, 32'd0);
`endif

    // randomized traffic, with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      rand_d();
      rst_n = ($urandom_range(0, 49) != 0);
      tick("rand");
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
